mpadd_arb2: RTL and testbench

Two-port round-robin arbiter and sequencer that shares one `mpadd256_serial` multi-precision adder between two requesters. It owns the adder's `write`/`start`/`ready` handshake, presents the granted requester's operands, and returns the 257-bit sum with a per-requester completion pulse. A watchdog aborts a hung addition so that neither requester can stall the shared datapath indefinitely.

---
 rtl/mpadd_arb2_if.sv | 30 +++
 rtl/mpadd_arb2.sv | 121 ++++++++++++
 tb/tb_mpadd_arb2.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mpadd_arb2_if.sv
// Shared adder bus between the arbiter (master) and one
// mpadd256_serial instance (slave).
interface mpadd_arb2_if #(
    parameter int WIDTH = 256
);
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_write;
    logic             add_start;
    logic             add_ready;
    logic [WIDTH:0]   add_s;

    modport master (
        output add_a,
        output add_b,
        output add_write,
        output add_start,
        input  add_ready,
        input  add_s
    );

    modport slave (
        input  add_a,
        input  add_b,
        input  add_write,
        input  add_start,
        output add_ready,
        output add_s
    );
endinterface

// File: rtl/mpadd_arb2.sv
// Two-port round-robin sequencer for one shared serial adder,
// with a watchdog that aborts additions that never complete.
module mpadd_arb2 #(
    parameter int WIDTH   = 256,
    parameter int TIMEOUT = 1023
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             err0,
    output logic             err1,
    output logic [WIDTH:0]   s_out,
    output logic             busy,
    mpadd_arb2_if.master     add
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [9:0] WD_LAST = 10'(TIMEOUT - 1);

    state_t     state;
    logic       last_gnt;
    logic       cur;
    logic [9:0] wdog;
    logic       pick1;

    // On a tie the requester that was not served last wins.
    assign pick1 = req1 && (!req0 || !last_gnt);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state         <= S_IDLE;
            last_gnt      <= 1'b1;
            cur           <= 1'b0;
            wdog          <= '0;
            gnt0          <= 1'b0;
            gnt1          <= 1'b0;
            done0         <= 1'b0;
            done1         <= 1'b0;
            err0          <= 1'b0;
            err1          <= 1'b0;
            s_out         <= '0;
            busy          <= 1'b0;
            add.add_a     <= '0;
            add.add_b     <= '0;
            add.add_write <= 1'b0;
            add.add_start <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        cur           <= pick1;
                        gnt0          <= !pick1;
                        gnt1          <= pick1;
                        add.add_a     <= pick1 ? a1 : a0;
                        add.add_b     <= pick1 ? b1 : b0;
                        add.add_write <= 1'b1;
                        busy          <= 1'b1;
                        state         <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    add.add_write <= 1'b0;
                    add.add_start <= 1'b1;
                    state         <= S_START;
                end
                S_START: begin
                    add.add_start <= 1'b0;
                    wdog          <= '0;
                    state         <= S_WAIT;
                end
                S_WAIT: begin
                    // Ready is checked first so it wins a same-edge timeout.
                    if (add.add_ready) begin
                        s_out <= add.add_s;
                        done0 <= !cur;
                        done1 <= cur;
                        state <= S_DONE;
                    end else if (wdog == WD_LAST) begin
                        s_out <= '0;
                        done0 <= !cur;
                        done1 <= cur;
                        err0  <= !cur;
                        err1  <= cur;
                        state <= S_DONE;
                    end else begin
                        wdog <= wdog + 10'd1;
                    end
                end
                S_DONE: begin
                    done0    <= 1'b0;
                    done1    <= 1'b0;
                    err0     <= 1'b0;
                    err1     <= 1'b0;
                    gnt0     <= 1'b0;
                    gnt1     <= 1'b0;
                    busy     <= 1'b0;
                    last_gnt <= cur;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mpadd_arb2.sv
// Directed and randomized bench for mpadd_arb2 with a
// behavioural serial-adder model of configurable latency.
module tb_mpadd_arb2;

    localparam int W   = 256;
    localparam int TMO = 8;

    logic           clk;
    logic           rst_n;
    logic           req0, req1;
    logic [W-1:0]   a0, b0, a1, b1;
    logic           gnt0, gnt1, done0, done1, err0, err1, busy;
    logic [W:0]     s_out;

    int checks;
    int failures;
    int lat;
    bit m_last;

    mpadd_arb2_if #(.WIDTH(W)) bus ();

    mpadd_arb2 #(.WIDTH(W), .TIMEOUT(TMO)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .req0  (req0),
        .req1  (req1),
        .a0    (a0),
        .b0    (b0),
        .a1    (a1),
        .b1    (b1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .done0 (done0),
        .done1 (done1),
        .err0  (err0),
        .err1  (err1),
        .s_out (s_out),
        .busy  (busy),
        .add   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder model: ready rises in the lat-th cycle after start (0 = never).
    logic [W-1:0] m_a, m_b;
    int           m_cnt;
    bit           m_run;

    always @(posedge clk) begin
        if (!rst_n) begin
            bus.add_ready <= 1'b0;
            bus.add_s     <= '0;
            m_run         <= 1'b0;
            m_cnt         <= 0;
        end else if (bus.add_write) begin
            m_a           <= bus.add_a;
            m_b           <= bus.add_b;
            bus.add_ready <= 1'b0;
            m_run         <= 1'b0;
        end else if (bus.add_start) begin
            bus.add_s <= {1'b0, m_a} + {1'b0, m_b};
            if (lat == 1) begin
                bus.add_ready <= 1'b1;
            end else if (lat > 1) begin
                m_cnt <= lat - 1;
                m_run <= 1'b1;
            end
        end else if (m_run) begin
            if (m_cnt == 1) begin
                bus.add_ready <= 1'b1;
                m_run         <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W:0] obs,
                       input logic [W:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_gnt0"}, 257'(gnt0), '0);
        chk({tag, "_gnt1"}, 257'(gnt1), '0);
        chk({tag, "_done0"}, 257'(done0), '0);
        chk({tag, "_done1"}, 257'(done1), '0);
        chk({tag, "_err0"}, 257'(err0), '0);
        chk({tag, "_err1"}, 257'(err1), '0);
        chk({tag, "_busy"}, 257'(busy), '0);
        chk({tag, "_write"}, 257'(bus.add_write), '0);
        chk({tag, "_start"}, 257'(bus.add_start), '0);
        chk({tag, "_add_a"}, 257'(bus.add_a), '0);
        chk({tag, "_add_b"}, 257'(bus.add_b), '0);
        chk({tag, "_s_out"}, s_out, '0);
    endtask

    // mode: 0 keep requests, 1 drop winner at done, 2 drop both at done,
    // 3 drop winner in the LOAD cycle.
    task automatic txn(input int mode);
        bit         w;
        bit         e_err;
        bit         seen;
        int         waits;
        logic [W-1:0] ea, eb;
        logic [W:0]   es;
        w     = (req0 && req1) ? !m_last : req1;
        ea    = w ? a1 : a0;
        eb    = w ? b1 : b0;
        e_err = !(lat >= 1 && lat <= TMO);
        es    = e_err ? '0 : ({1'b0, ea} + {1'b0, eb});
        tick();
        chk("load_write", 257'(bus.add_write), 257'(1));
        chk("load_start", 257'(bus.add_start), '0);
        chk("load_gnt", 257'(w ? gnt1 : gnt0), 257'(1));
        chk("load_gnt_other", 257'(w ? gnt0 : gnt1), '0);
        chk("load_busy", 257'(busy), 257'(1));
        chk("load_add_a", 257'(bus.add_a), 257'(ea));
        chk("load_add_b", 257'(bus.add_b), 257'(eb));
        if (mode == 3) begin
            if (w) req1 = 1'b0;
            else req0 = 1'b0;
        end
        tick();
        chk("start_start", 257'(bus.add_start), 257'(1));
        chk("start_write", 257'(bus.add_write), '0);
        waits = 0;
        seen  = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (done0 || done1) seen = 1'b1;
            else waits++;
        end
        chk("done_seen", 257'(seen), 257'(1));
        chk("wait_cycles", 257'(waits), 257'(e_err ? TMO : lat));
        chk("done_n", 257'(w ? done1 : done0), 257'(1));
        chk("done_other", 257'(w ? done0 : done1), '0);
        chk("err_n", 257'(w ? err1 : err0), 257'(e_err));
        chk("err_other", 257'(w ? err0 : err1), '0);
        chk("s_out", s_out, es);
        chk("done_gnt", 257'(w ? gnt1 : gnt0), 257'(1));
        chk("done_gnt_other", 257'(w ? gnt0 : gnt1), '0);
        m_last = w;
        if (mode == 1) begin
            if (w) req1 = 1'b0;
            else req0 = 1'b0;
        end else if (mode == 2) begin
            req0 = 1'b0;
            req1 = 1'b0;
        end
        tick();
        chk("idle_busy", 257'(busy), '0);
        chk("idle_gnt", 257'({gnt1, gnt0}), '0);
        chk("idle_done", 257'({done1, done0}), '0);
        chk("idle_s_hold", s_out, es);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        tick();
        tick();
        rst_n  = 1'b1;
        m_last = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        lat      = 3;
        m_last   = 1'b1;
        rst_n    = 1'b0;
        req0     = 1'b0;
        req1     = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        tick();
        tick();
        chk_idle_outs("rst");
        rst_n = 1'b1;
        tick();

        // Single request with carry out.
        a0   = '1;
        b0   = 256'd1;
        lat  = 3;
        req0 = 1'b1;
        txn(2);
        chk("carry_sum", s_out, {1'b1, 256'd0});

        // Simultaneous first requests after reset.
        do_reset();
        a0 = 256'd5;  b0 = 256'd7;
        a1 = 256'h10; b1 = 256'h20;
        lat  = 2;
        req0 = 1'b1;
        req1 = 1'b1;
        txn(1);
        chk("tie_first", s_out, 257'd12);
        txn(2);
        chk("tie_second", s_out, 257'h30);

        // Fairness with both requests held.
        req0 = 1'b1;
        req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a0 = rnd(); b0 = rnd(); a1 = rnd(); b1 = rnd();
            lat = $urandom_range(1, TMO);
            txn(k == 3 ? 2 : 0);
        end

        // Watchdog: never ready, ready at the limit, ready one too late.
        a0 = rnd(); b0 = rnd();
        lat = 0; req0 = 1'b1; txn(2);
        lat = TMO; req0 = 1'b1; txn(2);
        lat = TMO + 1; req0 = 1'b1; txn(2);

        // Randomized mix of requests and latencies.
        for (int k = 0; k < 16; k++) begin
            int r;
            r = $urandom_range(1, 3);
            req0 = r[0];
            req1 = r[1];
            a0 = rnd(); b0 = rnd(); a1 = rnd(); b1 = rnd();
            lat = $urandom_range(0, TMO + 1);
            txn(2);
        end

        // Reset while waiting on a hung adder.
        a0 = rnd(); b0 = rnd();
        lat  = 0;
        req0 = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("pre_rst_busy", 257'(busy), 257'(1));
        rst_n = 1'b0;
        tick();
        chk_idle_outs("wait_rst");
        req0   = 1'b0;
        rst_n  = 1'b1;
        m_last = 1'b1;
        tick();
        chk("post_rst_done", 257'({done1, done0}), '0);
        a0 = rnd(); b0 = rnd(); a1 = rnd(); b1 = rnd();
        lat  = 5;
        req0 = 1'b1;
        req1 = 1'b1;
        txn(1);
        txn(2);

        // Requester 1 drops its request right after grant.
        a1 = rnd(); b1 = rnd();
        lat  = 4;
        req1 = 1'b1;
        txn(3);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("no_retrigger_busy", 257'(busy), '0);
            chk("no_retrigger_write", 257'(bus.add_write), '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
